// File: rtl/avg_pool_if.sv
// Valid/ready stream bundle for the average-pool window accumulator:
// sample input side plus numerator/denominator output side.
interface avg_pool_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  avg_pool_ready_in;
  logic                  avg_pool_valid_in;
  logic [DATA_WIDTH-1:0] avg_pool_data_in;
  logic                  avg_pool_ready_out;
  logic                  avg_pool_valid_out;
  logic [DATA_WIDTH-1:0] avg_pool_numer_out;
  logic [DATA_WIDTH-1:0] avg_pool_denom_out;

  modport master (
    input  avg_pool_ready_in,
    output avg_pool_valid_in,
    output avg_pool_data_in,
    output avg_pool_ready_out,
    input  avg_pool_valid_out,
    input  avg_pool_numer_out,
    input  avg_pool_denom_out
  );

  modport slave (
    output avg_pool_ready_in,
    input  avg_pool_valid_in,
    input  avg_pool_data_in,
    input  avg_pool_ready_out,
    output avg_pool_valid_out,
    output avg_pool_numer_out,
    output avg_pool_denom_out
  );
endinterface

// File: rtl/avg_pool_accum.sv
// Sums non-overlapping windows of POOL_SIZE samples and hands sum/POOL_SIZE to the divider.
// Optional AVG_POOL_SATURATE_EN: clamp each addition to all-ones instead of wrapping.
module avg_pool_accum #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned POOL_SIZE  = 4
) (
  input  logic     clk,
  input  logic     rst,
  avg_pool_if.slave bus
);

  localparam int unsigned CNT_WIDTH = $clog2(POOL_SIZE);
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(POOL_SIZE - 32'd1);
  localparam logic [DATA_WIDTH-1:0] DENOM    = DATA_WIDTH'(POOL_SIZE);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] numer_q, numer_d;
  logic [DATA_WIDTH-1:0] denom_q, denom_d;
  logic                  valid_q, valid_d;
  logic                  ready_in_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] sum_s;

  function automatic logic [DATA_WIDTH-1:0] add_fn(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
`ifdef AVG_POOL_SATURATE_EN
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    // Once clamped, acc stays all-ones for the rest of the window since any further add overflows or adds zero.
    if (s[DATA_WIDTH]) begin
      add_fn = {DATA_WIDTH{1'b1}};
    end else begin
      add_fn = s[DATA_WIDTH-1:0];
    end
`else
    add_fn = a + b;
`endif
  endfunction

  assign ready_in_s = ~valid_q | bus.avg_pool_ready_out;
  assign accept_s   = bus.avg_pool_valid_in & ready_in_s;
  assign sum_s      = add_fn(acc_q, bus.avg_pool_data_in);

  assign bus.avg_pool_ready_in  = ready_in_s;
  assign bus.avg_pool_valid_out = valid_q;
  assign bus.avg_pool_numer_out = numer_q;
  assign bus.avg_pool_denom_out = denom_q;

  // Next-state: accumulate, close window into output regs, retire taken pair.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    numer_d = numer_q;
    denom_d = denom_q;
    valid_d = valid_q;
    if (valid_q & bus.avg_pool_ready_out) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (accept_s) begin
      if (cnt_q == CNT_LAST) begin
        // A close on the same edge as a take overrides the retire: no bubble.
        numer_d = sum_s;
        denom_d = DENOM;
        valid_d = 1'b1;
        acc_d   = {DATA_WIDTH{1'b0}};
        cnt_d   = {CNT_WIDTH{1'b0}};
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= {DATA_WIDTH{1'b0}};
      cnt_q   <= {CNT_WIDTH{1'b0}};
      numer_q <= {DATA_WIDTH{1'b0}};
      denom_q <= {DATA_WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      numer_q <= numer_d;
      denom_q <= denom_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_avg_pool_accum.sv
// Self-checking bench: two configurations (32b/4 and 8b/2) against a window-sum queue model.
module tb_avg_pool_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avg_pool_if #(.DATA_WIDTH(32)) bus0 ();
  avg_pool_if #(.DATA_WIDTH(8))  bus1 ();

  avg_pool_accum #(.DATA_WIDTH(32), .POOL_SIZE(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  avg_pool_accum #(.DATA_WIDTH(8),  .POOL_SIZE(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  longint win0[$];
  longint win1[$];
  bit     m_valid[2];
  longint m_numer[2];
  int     psize[2] = '{4, 2};
  int     dwid[2]  = '{32, 8};

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint window_sum(input longint q[$], input int w);
    longint s;
    longint mx;
    s  = 0;
    mx = (longint'(1) << w) - 1;
    foreach (q[k]) begin
      s = s + q[k];
`ifdef AVG_POOL_SATURATE_EN
      if (s > mx) s = mx;
`else
      s = s & mx;
`endif
    end
    return s;
  endfunction

  task automatic model_step(input int i, input bit rdy, input bit vout, input longint numer,
                            input longint denom, input bit vin, input longint din, input bit rout);
    bit     exp_ready;
    int     sz;
    longint s;
    if (rst) begin
      m_valid[i] = 1'b0;
      m_numer[i] = 0;
      if (i == 0) win0.delete(); else win1.delete();
      check($sformatf("i%0d_rst_valid", i), vout, 0);
      check($sformatf("i%0d_rst_numer", i), numer, 0);
      check($sformatf("i%0d_rst_denom", i), denom, 0);
      check($sformatf("i%0d_rst_ready", i), rdy, 1);
      return;
    end
    exp_ready = !m_valid[i] || rout;
    check($sformatf("i%0d_ready_in", i), rdy, exp_ready);
    check($sformatf("i%0d_valid_out", i), vout, m_valid[i]);
    if (m_valid[i]) begin
      check($sformatf("i%0d_numer", i), numer, m_numer[i]);
      check($sformatf("i%0d_denom", i), denom, psize[i]);
    end
    if (m_valid[i] && rout) m_valid[i] = 1'b0;
    if (vin && exp_ready) begin
      if (i == 0) begin
        win0.push_back(din);
        sz = win0.size();
        s  = window_sum(win0, dwid[0]);
      end else begin
        win1.push_back(din);
        sz = win1.size();
        s  = window_sum(win1, dwid[1]);
      end
      if (sz == psize[i]) begin
        m_numer[i] = s;
        m_valid[i] = 1'b1;
        if (i == 0) win0.delete(); else win1.delete();
      end
    end
  endtask

  // Single compare process: model and DUT checked on every falling edge.
  always @(negedge clk) begin
    model_step(0, bus0.avg_pool_ready_in, bus0.avg_pool_valid_out, longint'(bus0.avg_pool_numer_out),
               longint'(bus0.avg_pool_denom_out), bus0.avg_pool_valid_in,
               longint'(bus0.avg_pool_data_in), bus0.avg_pool_ready_out);
    model_step(1, bus1.avg_pool_ready_in, bus1.avg_pool_valid_out, longint'(bus1.avg_pool_numer_out),
               longint'(bus1.avg_pool_denom_out), bus1.avg_pool_valid_in,
               longint'(bus1.avg_pool_data_in), bus1.avg_pool_ready_out);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [31:0] d);
    bus0.avg_pool_valid_in = 1'b1;
    bus0.avg_pool_data_in  = d;
    step();
  endtask

  task automatic drive1(input logic [7:0] d);
    bus1.avg_pool_valid_in = 1'b1;
    bus1.avg_pool_data_in  = d;
    step();
  endtask

  longint q_lit[$];
  longint exp8;

  initial begin
    bus0.avg_pool_valid_in  = 1'b0;
    bus0.avg_pool_data_in   = 32'd0;
    bus0.avg_pool_ready_out = 1'b1;
    bus1.avg_pool_valid_in  = 1'b0;
    bus1.avg_pool_data_in   = 8'd0;
    bus1.avg_pool_ready_out = 1'b1;
`ifdef AVG_POOL_SATURATE_EN
    exp8 = 255;
`else
    exp8 = 44;
`endif
    q_lit = '{200, 100};
    check("model_sum8", window_sum(q_lit, 8), exp8);
    q_lit = '{1, 2, 3, 4};
    check("model_sum32", window_sum(q_lit, 32), 10);

    #1;
    check("rst_valid0", bus0.avg_pool_valid_out, 0);
    check("rst_ready0", bus0.avg_pool_ready_in, 1);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Single window 1..4, then 5..8 back to back.
    for (int k = 1; k <= 4; k++) begin
      check("ready_hi", bus0.avg_pool_ready_in, 1);
      drive0(32'(k));
    end
    check("w1_valid", bus0.avg_pool_valid_out, 1);
    check("w1_numer", bus0.avg_pool_numer_out, 10);
    check("w1_denom", bus0.avg_pool_denom_out, 4);
    drive0(32'd5);
    check("w1_onecycle", bus0.avg_pool_valid_out, 0);
    for (int k = 6; k <= 8; k++) drive0(32'(k));
    check("w2_valid", bus0.avg_pool_valid_out, 1);
    check("w2_numer", bus0.avg_pool_numer_out, 26);

    // Stall: hold the pair, input must back-pressure.
    bus0.avg_pool_valid_in = 1'b0;
    step();
    bus0.avg_pool_ready_out = 1'b0;
    for (int k = 1; k <= 4; k++) drive0(32'(k));
    bus0.avg_pool_valid_in = 1'b1;
    bus0.avg_pool_data_in  = 32'd5;
    for (int k = 0; k < 3; k++) begin
      check("stall_ready", bus0.avg_pool_ready_in, 0);
      check("stall_numer", bus0.avg_pool_numer_out, 10);
      step();
    end
    bus0.avg_pool_ready_out = 1'b1;
    step();
    for (int k = 6; k <= 8; k++) drive0(32'(k));
    check("stall_w2_numer", bus0.avg_pool_numer_out, 26);

    // Asynchronous reset mid-window.
    bus0.avg_pool_valid_in = 1'b0;
    step();
    drive0(32'd5);
    drive0(32'd6);
    bus0.avg_pool_valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", bus0.avg_pool_valid_out, 0);
    check("async_rst_numer", bus0.avg_pool_numer_out, 0);
    check("async_rst_ready", bus0.avg_pool_ready_in, 1);
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) drive0(32'd1);
    check("post_rst_numer", bus0.avg_pool_numer_out, 4);
    bus0.avg_pool_valid_in = 1'b0;
    step();

    // 8-bit, window of 2: wrap or clamp.
    drive1(8'd200);
    drive1(8'd100);
    check("w8_numer", bus1.avg_pool_numer_out, exp8);
    check("w8_denom", bus1.avg_pool_denom_out, 2);
    // Stalled pair then released while samples keep streaming.
    bus1.avg_pool_ready_out = 1'b0;
    bus1.avg_pool_data_in   = 8'd7;
    repeat (3) step();
    bus1.avg_pool_ready_out = 1'b1;
    for (int k = 0; k < 6; k++) drive1(8'(k + 3));
    bus1.avg_pool_valid_in = 1'b0;
    step();

    // Randomized traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      bus0.avg_pool_valid_in  = ($urandom_range(0, 3) != 0);
      bus0.avg_pool_data_in   = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 1000));
      bus0.avg_pool_ready_out = ($urandom_range(0, 3) != 0);
      bus1.avg_pool_valid_in  = ($urandom_range(0, 3) != 0);
      bus1.avg_pool_data_in   = 8'($urandom_range(0, 255));
      bus1.avg_pool_ready_out = ($urandom_range(0, 2) != 0);
      step();
    end
    bus0.avg_pool_valid_in  = 1'b0;
    bus1.avg_pool_valid_in  = 1'b0;
    bus0.avg_pool_ready_out = 1'b1;
    bus1.avg_pool_ready_out = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
